// File: rtl/scr_mon_pkg.sv
// Shared types and 50 MHz default timing for the SCR breakdown/BOD monitor.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package scr_mon_pkg;

  // Detector sequence states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOD_WIN,
    ST_BLANK,
    ST_BRK_WIN
  } det_state_e;

  // Default windows at 50 MHz: BOD 500 us, blanking to 848 us, breakdown window to 10 ms
  localparam int DEF_CNT_W     = 20;
  localparam int DEF_T_BOD     = 25000;
  localparam int DEF_T_BLANK   = 42400;
  localparam int DEF_T_END     = 500000;
  localparam int DEF_FILT_LEN  = 8;
  localparam int DEF_CNT_SAT_W = 8;

  // Position of a detector in the packed counter bus: fwd-trigger detector even, neg odd
  function automatic int det_idx(input int ch, input bit neg_trig);
    return 2 * ch + (neg_trig ? 1 : 0);
  endfunction

endpackage

// File: rtl/scr_window_det.sv
// One trigger-polarity detector: timed BOD / blank / breakdown windows on a feedback edge.
// Latency: results and done strobe register one clock after the deciding edge or window end.
// Backpressure: none; trigger edges while busy restart (RETRIG=1) or are dropped (RETRIG=0).
module scr_window_det
  import scr_mon_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_BOD     = DEF_T_BOD,
  parameter int T_BLANK   = DEF_T_BLANK,
  parameter int T_END     = DEF_T_END,
  parameter int RETRIG    = 0,
  parameter int CNT_SAT_W = DEF_CNT_SAT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_edge_i,
  input  logic                 fb_edge_i,
  input  logic                 forbid_i,
  input  logic                 cnt_clr_i,
  output logic                 brk_o,
  output logic                 bod_o,
  output logic                 done_o,
  output logic [CNT_SAT_W-1:0] brk_cnt_o
);

  localparam logic [CNT_W-1:0] T_BOD_C   = CNT_W'(T_BOD);
  localparam logic [CNT_W-1:0] T_BLANK_C = CNT_W'(T_BLANK);
  localparam logic [CNT_W-1:0] T_END_C   = CNT_W'(T_END);

  det_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bod_f_q, bod_f_d;
  logic                 brk_q, brk_d;
  logic                 bod_q, bod_d;
  logic                 done_q, done_d;
  logic [CNT_SAT_W-1:0] sat_q, sat_d;

  // State, window counter, results and fault counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bod_f_q <= 1'b0;
      brk_q   <= 1'b0;
      bod_q   <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bod_f_q <= bod_f_d;
      brk_q   <= brk_d;
      bod_q   <= bod_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  // Window sequencing, completion, retrigger, forbid override and counter clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bod_f_d = bod_f_q;
    brk_d   = brk_q;
    bod_d   = bod_q;
    done_d  = 1'b0;
    sat_d   = sat_q;

    case (state_q)
      ST_IDLE: begin
        if (trig_edge_i) begin
          state_d = ST_BOD_WIN;
          cnt_d   = CNT_W'(1);
          bod_f_d = 1'b0;
        end
      end
      ST_BOD_WIN: begin
        cnt_d = cnt_q + 1'b1;
        if (fb_edge_i) bod_f_d = 1'b1;
        if (cnt_q == T_BOD_C) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == T_BLANK_C) state_d = ST_BRK_WIN;
      end
      ST_BRK_WIN: begin
        // An edge on the last counted clock still counts as breakdown
        if (fb_edge_i || (cnt_q == T_END_C)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          brk_d   = fb_edge_i;
          bod_d   = bod_f_q;
          done_d  = 1'b1;
          if (fb_edge_i && (sat_q != '1)) sat_d = sat_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Restart only if this clock is not already completing; a coincident edge is lost
    if ((RETRIG != 0) && trig_edge_i && (state_q != ST_IDLE) && !done_d) begin
      state_d = ST_BOD_WIN;
      cnt_d   = CNT_W'(1);
      bod_f_d = 1'b0;
    end

    // Forbid parks the detector and shows "light on" until the next real completion
    if (forbid_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      bod_f_d = 1'b0;
      brk_d   = 1'b1;
      bod_d   = 1'b1;
      done_d  = 1'b0;
      sat_d   = sat_q;
    end

    if (cnt_clr_i) sat_d = '0;
  end

  assign brk_o     = brk_q;
  assign bod_o     = bod_q;
  assign done_o    = done_q;
  assign brk_cnt_o = sat_q;

endmodule

// File: rtl/scr_breakdown_monitor.sv
// Multi-channel SCR breakdown/BOD monitor: input sync, feedback glitch filter, 2 detectors/channel.
// Latency: trigger pin to detector 2 clocks; feedback pin to edge 2+FILT_LEN clocks; results +1.
// Backpressure: none; outputs are result levels and one-clock completion strobes.
module scr_breakdown_monitor
  import scr_mon_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_BOD     = DEF_T_BOD,
  parameter int T_BLANK   = DEF_T_BLANK,
  parameter int T_END     = DEF_T_END,
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int RETRIG    = 0,
  parameter int CNT_SAT_W = DEF_CNT_SAT_W
) (
  input  logic                          i_clk_50m,
  input  logic                          i_rst,
  input  logic [N_CH-1:0]               i_signal,
  input  logic [N_CH-1:0]               i_signal_forward,
  input  logic [N_CH-1:0]               i_signal_negative,
  input  logic                          i_signal_forbid,
  input  logic                          i_cnt_clr,
  output logic [N_CH-1:0]               o_brk_fwd,
  output logic [N_CH-1:0]               o_brk_neg,
  output logic [N_CH-1:0]               o_bod_fwd,
  output logic [N_CH-1:0]               o_bod_neg,
  output logic [N_CH-1:0]               o_done_fwd,
  output logic [N_CH-1:0]               o_done_neg,
  output logic [2*N_CH*CNT_SAT_W-1:0]   o_brk_cnt
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);

  logic [N_CH-1:0] fwd_meta_q, fwd_sync_q, fwd_prev_q;
  logic [N_CH-1:0] neg_meta_q, neg_sync_q, neg_prev_q;
  logic [N_CH-1:0] fb_meta_q, fb_sync_q;
  logic [N_CH-1:0] filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]   filt_cnt_q [N_CH];
  logic [FW-1:0]   filt_cnt_d [N_CH];

  logic [N_CH-1:0] fwd_edge, neg_edge, fb_edge;

  // Two-flop synchronisers, trigger edge history and filter state
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      fwd_meta_q  <= '0;
      fwd_sync_q  <= '0;
      fwd_prev_q  <= '0;
      neg_meta_q  <= '0;
      neg_sync_q  <= '0;
      neg_prev_q  <= '0;
      fb_meta_q   <= '0;
      fb_sync_q   <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int c = 0; c < N_CH; c++) filt_cnt_q[c] <= '0;
    end else begin
      fwd_meta_q  <= i_signal_forward;
      fwd_sync_q  <= fwd_meta_q;
      fwd_prev_q  <= fwd_sync_q;
      neg_meta_q  <= i_signal_negative;
      neg_sync_q  <= neg_meta_q;
      neg_prev_q  <= neg_sync_q;
      fb_meta_q   <= i_signal;
      fb_sync_q   <= fb_meta_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      for (int c = 0; c < N_CH; c++) filt_cnt_q[c] <= filt_cnt_d[c];
    end
  end

  // Filtered feedback follows the synced input only after FILT_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    for (int c = 0; c < N_CH; c++) begin
      filt_cnt_d[c] = '0;
      if (fb_sync_q[c] != filt_q[c]) begin
        if (filt_cnt_q[c] == FILT_MAX) begin
          filt_d[c] = fb_sync_q[c];
        end else begin
          filt_cnt_d[c] = filt_cnt_q[c] + 1'b1;
        end
      end
    end
  end

  // Edge history keeps tracking during forbid, so releasing it never fakes a trigger
  assign fwd_edge = fwd_sync_q & ~fwd_prev_q;
  assign neg_edge = neg_sync_q & ~neg_prev_q;
  assign fb_edge  = filt_q & ~filt_prev_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int K_FWD = det_idx(c, 1'b0);
    localparam int K_NEG = det_idx(c, 1'b1);

    // Forward trigger: early edge is forward BOD, late edge is negative breakdown
    scr_window_det #(
      .CNT_W(CNT_W), .T_BOD(T_BOD), .T_BLANK(T_BLANK), .T_END(T_END),
      .RETRIG(RETRIG), .CNT_SAT_W(CNT_SAT_W)
    ) u_det_fwd (
      .clk_i      (i_clk_50m),
      .rst_i      (i_rst),
      .trig_edge_i(fwd_edge[c]),
      .fb_edge_i  (fb_edge[c]),
      .forbid_i   (i_signal_forbid),
      .cnt_clr_i  (i_cnt_clr),
      .brk_o      (o_brk_neg[c]),
      .bod_o      (o_bod_fwd[c]),
      .done_o     (o_done_fwd[c]),
      .brk_cnt_o  (o_brk_cnt[K_FWD*CNT_SAT_W +: CNT_SAT_W])
    );

    // Negative trigger: early edge is negative BOD, late edge is forward breakdown
    scr_window_det #(
      .CNT_W(CNT_W), .T_BOD(T_BOD), .T_BLANK(T_BLANK), .T_END(T_END),
      .RETRIG(RETRIG), .CNT_SAT_W(CNT_SAT_W)
    ) u_det_neg (
      .clk_i      (i_clk_50m),
      .rst_i      (i_rst),
      .trig_edge_i(neg_edge[c]),
      .fb_edge_i  (fb_edge[c]),
      .forbid_i   (i_signal_forbid),
      .cnt_clr_i  (i_cnt_clr),
      .brk_o      (o_brk_fwd[c]),
      .bod_o      (o_bod_neg[c]),
      .done_o     (o_done_neg[c]),
      .brk_cnt_o  (o_brk_cnt[K_NEG*CNT_SAT_W +: CNT_SAT_W])
    );
  end

endmodule

// File: tb/tb_scr_breakdown_monitor.sv
// Directed bench for scr_breakdown_monitor with short windows (BOD 10, blank 20, end 50, filter 2).
// Two instances share stimulus: a_* has RETRIG=0, b_* has RETRIG=1.
// Inputs change on the falling edge; outputs are sampled there too, before new inputs apply.
module tb_scr_breakdown_monitor;

  localparam int N_CH = 2;
  localparam int SW   = 8;
  localparam int CW   = 2 * N_CH * SW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [N_CH-1:0] sig = '0, fwd = '0, neg = '0;
  logic            forbid = 1'b0, clr = 1'b0;

  logic [N_CH-1:0] a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg, a_done_fwd, a_done_neg;
  logic [N_CH-1:0] b_brk_fwd, b_brk_neg, b_bod_fwd, b_bod_neg, b_done_fwd, b_done_neg;
  logic [CW-1:0]   a_cnt, b_cnt;

  int total = 0;
  int bad   = 0;

  scr_breakdown_monitor #(
    .N_CH(N_CH), .CNT_W(20), .T_BOD(10), .T_BLANK(20), .T_END(50),
    .FILT_LEN(2), .RETRIG(0), .CNT_SAT_W(SW)
  ) dut_a (
    .i_clk_50m(clk), .i_rst(rst), .i_signal(sig), .i_signal_forward(fwd),
    .i_signal_negative(neg), .i_signal_forbid(forbid), .i_cnt_clr(clr),
    .o_brk_fwd(a_brk_fwd), .o_brk_neg(a_brk_neg), .o_bod_fwd(a_bod_fwd),
    .o_bod_neg(a_bod_neg), .o_done_fwd(a_done_fwd), .o_done_neg(a_done_neg),
    .o_brk_cnt(a_cnt)
  );

  scr_breakdown_monitor #(
    .N_CH(N_CH), .CNT_W(20), .T_BOD(10), .T_BLANK(20), .T_END(50),
    .FILT_LEN(2), .RETRIG(1), .CNT_SAT_W(SW)
  ) dut_b (
    .i_clk_50m(clk), .i_rst(rst), .i_signal(sig), .i_signal_forward(fwd),
    .i_signal_negative(neg), .i_signal_forbid(forbid), .i_cnt_clr(clr),
    .o_brk_fwd(b_brk_fwd), .o_brk_neg(b_brk_neg), .o_bod_fwd(b_bod_fwd),
    .o_bod_neg(b_bod_neg), .o_done_fwd(b_done_fwd), .o_done_neg(b_done_neg),
    .o_brk_cnt(b_cnt)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Trigger pulse at tick 0 (3 clocks). A feedback edge meant to hit window count c is driven
  // at tick c-2 for 4 clocks; completion at count c is visible at tick c+3. Optional retrigger
  // at tick rt and counter clear at tick clr_t (-1 disables). Records done strobes seen.
  task automatic run_seq(input int ch, input bit pol_neg, input int e1, input int e2,
                         input int rt, input int clr_t, input int ticks,
                         output int a_first, output int a_num, output int b_first);
    logic a_d, b_d, trg;
    a_first = -1;
    b_first = -1;
    a_num   = 0;
    for (int t = 0; t < ticks; t++) begin
      a_d = pol_neg ? a_done_neg[ch] : a_done_fwd[ch];
      b_d = pol_neg ? b_done_neg[ch] : b_done_fwd[ch];
      if (a_d) begin
        a_num++;
        if (a_first < 0) a_first = t;
      end
      if (b_d && (b_first < 0)) b_first = t;
      trg = (t < 3) || ((rt >= 0) && (t >= rt) && (t < rt + 3));
      if (pol_neg) neg[ch] = trg;
      else         fwd[ch] = trg;
      sig[ch] = ((e1 >= 0) && (t >= e1 - 2) && (t <= e1 + 1)) ||
                ((e2 >= 0) && (t >= e2 - 2) && (t <= e2 + 1));
      clr = (t == clr_t);
      @(negedge clk);
    end
    fwd = '0;
    neg = '0;
    sig = '0;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    total++; if ({a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg} !== 8'h00) begin
      bad++; $display("FAIL reset_results: got %h expected 00", {a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg});
    end
    total++; if ({a_done_fwd, a_done_neg} !== 4'h0) begin
      bad++; $display("FAIL reset_done: got %h expected 0", {a_done_fwd, a_done_neg});
    end
    total++; if (a_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt: got %h expected 0", a_cnt);
    end
    total++; if ({b_brk_fwd, b_brk_neg, b_bod_fwd, b_bod_neg, b_cnt} !== '0) begin
      bad++; $display("FAIL reset_b: got nonzero outputs on retrig instance");
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_fwd_no_feedback;
    int af, an, bf;
    run_seq(0, 1'b0, -1, -1, -1, -1, 60, af, an, bf);
    total++; if (af !== 53 || an !== 1) begin
      bad++; $display("FAIL nofb_done: got tick %0d count %0d expected tick 53 count 1", af, an);
    end
    total++; if (bf !== 53) begin
      bad++; $display("FAIL nofb_done_b: got tick %0d expected 53", bf);
    end
    total++; if (a_brk_neg[0] !== 1'b0 || a_bod_fwd[0] !== 1'b0) begin
      bad++; $display("FAIL nofb_results: got brk=%b bod=%b expected 0 0", a_brk_neg[0], a_bod_fwd[0]);
    end
  endtask

  task automatic test_fwd_bod_brk;
    int af, an, bf;
    run_seq(0, 1'b0, 5, 30, -1, -1, 60, af, an, bf);
    total++; if (af !== 33 || an !== 1) begin
      bad++; $display("FAIL bodbrk_done: got tick %0d count %0d expected tick 33 count 1", af, an);
    end
    total++; if (a_bod_fwd[0] !== 1'b1 || a_brk_neg[0] !== 1'b1) begin
      bad++; $display("FAIL bodbrk_results: got bod=%b brk=%b expected 1 1", a_bod_fwd[0], a_brk_neg[0]);
    end
    total++; if (a_brk_fwd[0] !== 1'b0 || a_bod_neg[0] !== 1'b0) begin
      bad++; $display("FAIL bodbrk_other_pol: got brk_fwd=%b bod_neg=%b expected 0 0", a_brk_fwd[0], a_bod_neg[0]);
    end
    total++; if (a_cnt[0*SW +: SW] !== 8'd1) begin
      bad++; $display("FAIL bodbrk_cnt: got %0d expected 1", a_cnt[0*SW +: SW]);
    end
  endtask

  task automatic test_blank_and_end;
    int af, an, bf;
    run_seq(0, 1'b0, 15, -1, -1, -1, 60, af, an, bf);
    total++; if (af !== 53) begin
      bad++; $display("FAIL blank_done: got tick %0d expected 53", af);
    end
    total++; if (a_brk_neg[0] !== 1'b0 || a_bod_fwd[0] !== 1'b0) begin
      bad++; $display("FAIL blank_results: got brk=%b bod=%b expected 0 0", a_brk_neg[0], a_bod_fwd[0]);
    end
    run_seq(0, 1'b0, 50, -1, -1, -1, 60, af, an, bf);
    total++; if (af !== 53 || a_brk_neg[0] !== 1'b1 || a_bod_fwd[0] !== 1'b0) begin
      bad++; $display("FAIL edge_at_end: got tick %0d brk=%b bod=%b expected 53 1 0", af, a_brk_neg[0], a_bod_fwd[0]);
    end
    total++; if (a_cnt[0*SW +: SW] !== 8'd2) begin
      bad++; $display("FAIL edge_at_end_cnt: got %0d expected 2", a_cnt[0*SW +: SW]);
    end
  endtask

  task automatic test_neg_polarity;
    int af, an, bf;
    run_seq(1, 1'b1, 5, 30, -1, -1, 60, af, an, bf);
    total++; if (af !== 33) begin
      bad++; $display("FAIL neg_done: got tick %0d expected 33", af);
    end
    total++; if (a_bod_neg[1] !== 1'b1 || a_brk_fwd[1] !== 1'b1 || a_brk_neg[1] !== 1'b0) begin
      bad++; $display("FAIL neg_results: got bod_neg=%b brk_fwd=%b brk_neg=%b expected 1 1 0",
                      a_bod_neg[1], a_brk_fwd[1], a_brk_neg[1]);
    end
    total++; if (a_cnt[3*SW +: SW] !== 8'd1 || a_cnt[2*SW +: SW] !== 8'd0) begin
      bad++; $display("FAIL neg_cnt: got k3=%0d k2=%0d expected 1 0", a_cnt[3*SW +: SW], a_cnt[2*SW +: SW]);
    end
  endtask

  task automatic test_forbid;
    int af, an, bf, dn;
    dn = 0;
    fwd[0] = 1'b1;
    tick(3);
    fwd[0] = 1'b0;
    tick(27);                 // sequence now inside the breakdown window
    forbid = 1'b1;
    fwd[0] = 1'b1;            // trigger rises while forbidden
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if ((a_done_fwd | a_done_neg) !== '0) dn++;
    end
    total++; if ({a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg} !== 8'hFF) begin
      bad++; $display("FAIL forbid_light_on: got %h expected ff", {a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg});
    end
    total++; if (a_cnt[0*SW +: SW] !== 8'd2) begin
      bad++; $display("FAIL forbid_cnt_hold: got %0d expected 2", a_cnt[0*SW +: SW]);
    end
    forbid = 1'b0;            // release with trigger still high: no new sequence may start
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if ((a_done_fwd | a_done_neg) !== '0) dn++;
    end
    total++; if (dn !== 0) begin
      bad++; $display("FAIL forbid_no_done: got %0d strobes expected 0", dn);
    end
    fwd[0] = 1'b0;
    tick(3);
    run_seq(0, 1'b0, -1, -1, -1, -1, 60, af, an, bf);
    total++; if (af !== 53 || a_brk_neg[0] !== 1'b0 || a_bod_fwd[0] !== 1'b0) begin
      bad++; $display("FAIL forbid_after: got tick %0d brk=%b bod=%b expected 53 0 0", af, a_brk_neg[0], a_bod_fwd[0]);
    end
  endtask

  task automatic test_retrig;
    int af, an, bf;
    run_seq(0, 1'b0, -1, -1, 25, -1, 90, af, an, bf);
    total++; if (af !== 53 || an !== 1) begin
      bad++; $display("FAIL retrig0: got tick %0d count %0d expected tick 53 count 1", af, an);
    end
    total++; if (bf !== 78) begin
      bad++; $display("FAIL retrig1: got tick %0d expected 78", bf);
    end
  endtask

  task automatic test_saturate_and_clear;
    int af, an, bf, late;
    late = 0;
    for (int i = 0; i < 300; i++) begin
      run_seq(1, 1'b0, 21, -1, -1, -1, 30, af, an, bf);
      if (af != 24) late++;
      if (i == 254) begin
        total++; if (a_cnt[2*SW +: SW] !== 8'd255) begin
          bad++; $display("FAIL sat_reach: got %0d expected 255", a_cnt[2*SW +: SW]);
        end
      end
    end
    total++; if (late !== 0) begin
      bad++; $display("FAIL sat_timing: got %0d off-time completions expected 0", late);
    end
    total++; if (a_cnt[2*SW +: SW] !== 8'd255 || a_brk_neg[1] !== 1'b1) begin
      bad++; $display("FAIL sat_hold: got %0d brk=%b expected 255 1", a_cnt[2*SW +: SW], a_brk_neg[1]);
    end
    run_seq(1, 1'b0, 21, -1, -1, 23, 30, af, an, bf);
    total++; if (af !== 24 || a_cnt[2*SW +: SW] !== 8'd0 || a_cnt[0*SW +: SW] !== 8'd0) begin
      bad++; $display("FAIL clr_wins: got tick %0d k2=%0d k0=%0d expected 24 0 0",
                      af, a_cnt[2*SW +: SW], a_cnt[0*SW +: SW]);
    end
  endtask

  task automatic test_reset_mid;
    int dn;
    dn = 0;
    fwd[0] = 1'b1;
    tick(3);
    fwd[0] = 1'b0;
    tick(7);
    rst = 1'b1;
    forbid = 1'b1;            // reset must win over forbid
    tick(2);
    total++; if ({a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg, a_done_fwd, a_done_neg} !== '0 || a_cnt !== '0) begin
      bad++; $display("FAIL rst_mid: got results %h cnt %h expected 0",
                      {a_brk_fwd, a_brk_neg, a_bod_fwd, a_bod_neg}, a_cnt);
    end
    rst = 1'b0;
    forbid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if ((a_done_fwd | a_done_neg | b_done_fwd | b_done_neg) !== '0) dn++;
    end
    total++; if (dn !== 0) begin
      bad++; $display("FAIL rst_no_resume: got %0d strobes expected 0", dn);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fwd_no_feedback();
    test_fwd_bod_brk();
    test_blank_and_end();
    test_neg_polarity();
    test_forbid();
    test_retrig();
    test_saturate_and_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
